multi_timer: RTL and testbench

Multi-channel, button-triggered LED pulse timer: each channel detects a rising edge on its button input and drives its LED high for a fixed duration. Each channel then returns to idle and emits a one-cycle done pulse. It generalises the single-button/single-LED timer to CHANNELS independent channels, adds per-channel retrigger mode, done/busy status and an optional tick prescaler. It sits between the synchronised board button inputs and the LED outputs.

---
 rtl/multi_timer.sv | 127 ++++++++++++
 tb/tb_multi_timer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// Multi-channel button-triggered LED pulse timer with one-shot/retrigger mode per channel.
// Optional shared tick prescaler is enabled by defining TIMER_PRESCALE_EN.
module multi_timer #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  parameter int DURATION = 50,
  parameter int PRESCALE = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] button,
  input  logic [CHANNELS-1:0] mode,
  output logic [CHANNELS-1:0] LED,
  output logic [CHANNELS-1:0] done,
  output logic                busy,
  output logic [CHANNELS-1:0] dbg_state
);

  // Handshake: none; button is a level input, done is a single-cycle strobe with no ready.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DURATION - 1);

  if (CHANNELS < 1 || CHANNELS > 16 || DURATION < 1 || DURATION >= (1 << CNT_W))
  begin : g_bad_params
    $error("multi_timer: illegal CHANNELS/DURATION for CNT_W");
  end

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] btn_q;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] led_d;
  logic [CHANNELS-1:0] done_d;
  logic                tick;

`ifdef TIMER_PRESCALE_EN
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("multi_timer: PRESCALE must be >= 2");
  end

  localparam int PS_W = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q;

  assign tick = (ps_q == PS_MAX);

  always_ff @(posedge clk) begin
    if (rst)       ps_q <= '0;
    else if (tick) ps_q <= '0;
    else           ps_q <= ps_q + 1'b1;
  end
`else
  if (PRESCALE < 0) begin : g_prescale_ignored
    $error("multi_timer: PRESCALE must be non-negative");
  end

  assign tick = 1'b1;
`endif

  assign rise = button & ~btn_q;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      done_d[i]  = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (rise[i]) begin
            cnt_d[i]   = RELOAD;
            state_d[i] = RUN;
          end
        end
        RUN: begin
          // A retrigger reload wins over a same-cycle expiry: LED stays lit, no done.
          if (rise[i] && mode[i]) begin
            cnt_d[i] = RELOAD;
          end else if (tick) begin
            if (cnt_q[i] == '0) begin
              state_d[i] = IDLE;
              done_d[i]  = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] - 1'b1;
            end
          end
        end
        default: state_d[i] = IDLE;
      endcase
      led_d[i] = (state_d[i] == RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // All-ones so a button held through reset is not seen as a fresh press.
      btn_q <= '1;
      LED   <= '0;
      done  <= '0;
      busy  <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      btn_q <= button;
      LED   <= led_d;
      done  <= done_d;
      busy  <= |led_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      dbg_state[i] = (state_q[i] == RUN);
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: per-cycle expected {busy, done, LED} words are
// queued as stimulus is applied and compared one cycle later.
module tb_multi_timer;

  localparam int CH = 2;
  localparam int CW = 8;
`ifdef TIMER_PRESCALE_EN
  localparam int DUR = 3;
`else
  localparam int DUR = 5;
`endif
  localparam int PS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] button;
  logic [CH-1:0] mode;
  logic [CH-1:0] led;
  logic [CH-1:0] done;
  logic          busy;
  logic [CH-1:0] dbg_state;

  logic [4:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_timer #(
    .CHANNELS(CH),
    .CNT_W   (CW),
    .DURATION(DUR),
    .PRESCALE(PS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .button   (button),
    .mode     (mode),
    .LED      (led),
    .done     (done),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  // Apply inputs, let one rising edge sample them, then settle away from the edge.
  task automatic drive(input logic r, input logic [CH-1:0] b, input logic [CH-1:0] m);
    rst    = r;
    button = b;
    mode   = m;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] mk(input logic [1:0] l, input logic [1:0] d);
    return {|l, d, l};
  endfunction

  function automatic logic inw(input int j, input int lo, input int hi);
    return (j >= lo) && (j <= hi);
  endfunction

  task automatic test_reset;
    logic [4:0] e;
    for (int j = 0; j < 8; j++) begin
      exp_q.push_back(5'b0);
      drive(j < 2, (j < 6) ? 2'b11 : 2'b00, 2'b00);
      e = exp_q.pop_front();
      n_checks++;
      if ({busy, done, led} !== e || dbg_state !== 2'b00) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got %b state %b, want %b", j, {busy, done, led}, dbg_state, e);
      end
    end
  endtask

  task automatic test_basic;
    logic [4:0] e;
    for (int j = 0; j < 12; j++) begin
      exp_q.push_back(mk({1'b0, inw(j, 2, 1 + DUR)}, {1'b0, j == 2 + DUR}));
      drive(1'b0, {1'b0, inw(j, 2, 4)}, 2'b00);
      e = exp_q.pop_front();
      n_checks++;
      if ({busy, done, led} !== e) begin
        n_fail++;
        $display("FAIL basic cycle %0d: got %b want %b", j, {busy, done, led}, e);
      end
    end
  endtask

  task automatic test_oneshot;
    logic [4:0] e;
    for (int j = 0; j < 12; j++) begin
      exp_q.push_back(mk({1'b0, inw(j, 2, 1 + DUR)}, {1'b0, j == 2 + DUR}));
      drive(1'b0, {1'b0, (j == 2) || inw(j, 4, 5)}, 2'b00);
      e = exp_q.pop_front();
      n_checks++;
      if ({busy, done, led} !== e) begin
        n_fail++;
        $display("FAIL oneshot cycle %0d: got %b want %b", j, {busy, done, led}, e);
      end
    end
  endtask

  task automatic test_retrigger;
    logic [4:0] e;
    logic       l0;
    logic       d0;
    for (int j = 0; j < 28; j++) begin
      // Rises at 2 and 5 (reload), then at 14 and exactly on its expiry edge 14+DUR.
      l0 = inw(j, 2, 4 + DUR) || inw(j, 14, 13 + 2 * DUR);
      d0 = (j == 5 + DUR) || (j == 14 + 2 * DUR);
      exp_q.push_back(mk({1'b0, l0}, {1'b0, d0}));
      drive(1'b0, {1'b0, (j == 2) || (j == 5) || (j == 14) || (j == 14 + DUR)}, 2'b01);
      e = exp_q.pop_front();
      n_checks++;
      if ({busy, done, led} !== e) begin
        n_fail++;
        $display("FAIL retrigger cycle %0d: got %b want %b", j, {busy, done, led}, e);
      end
    end
  endtask

  task automatic test_concurrent;
    logic [4:0] e;
    logic [1:0] l;
    logic [1:0] d;
    logic [1:0] b;
    for (int j = 0; j < 26; j++) begin
      l[0] = inw(j, 2, 3) || inw(j, 6, 5 + DUR) || inw(j, 16, 15 + DUR);
      l[1] = inw(j, 2, 3) || inw(j, 6, 5 + DUR) || inw(j, 14, 13 + DUR);
      d[0] = (j == 6 + DUR) || (j == 16 + DUR);
      d[1] = (j == 6 + DUR) || (j == 14 + DUR);
      b[0] = (j == 2) || (j == 6) || (j == 16);
      b[1] = (j == 2) || (j == 6) || (j == 14);
      exp_q.push_back(mk(l, d));
      drive(j == 4, b, 2'b00);
      e = exp_q.pop_front();
      n_checks++;
      if ({busy, done, led} !== e) begin
        n_fail++;
        $display("FAIL concurrent cycle %0d: got %b want %b", j, {busy, done, led}, e);
      end
    end
  endtask

  task automatic test_prescale;
    int high_cnt = 0;
    int done_cnt = 0;
    int lo_exp;
    int hi_exp;
    logic [4:0] e;
    lo_exp = (DUR - 1) * PS + 1;
    hi_exp = DUR * PS;
    exp_q.push_back(5'd1);
    for (int j = 0; j < 5 * PS * DUR; j++) begin
      drive(1'b0, {1'b0, j == 3}, 2'b00);
      if (led[0]) high_cnt++;
      if (done[0]) begin
        done_cnt++;
        n_checks++;
        if (led[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL prescale done-with-led cycle %0d: got led %b want 0", j, led[0]);
        end
      end
    end
    e = exp_q.pop_front();
    n_checks++;
    if (done_cnt !== int'(e)) begin
      n_fail++;
      $display("FAIL prescale done count: got %0d want %0d", done_cnt, e);
    end
    n_checks++;
    if (high_cnt < lo_exp || high_cnt > hi_exp) begin
      n_fail++;
      $display("FAIL prescale on-time: got %0d want %0d..%0d", high_cnt, lo_exp, hi_exp);
    end
  endtask

  initial begin
    rst    = 1'b1;
    button = 2'b11;
    mode   = 2'b00;
    test_reset();
`ifdef TIMER_PRESCALE_EN
    test_prescale();
`else
    test_basic();
    test_oneshot();
    test_retrigger();
    test_concurrent();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
